hidden_neuron_mac: RTL



---
 rtl/hidden_layer_pkg.sv | 43 ++++
 rtl/hidden_neuron_mac_mult.sv | 32 +++
 rtl/hidden_neuron_mac.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hidden_layer_pkg.sv
// Shared state type, default widths and fixed-point helpers for the
// hidden-layer neuron engines.
package hidden_layer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } macState_t;

  localparam int unsigned DefNumIn     = 16;
  localparam int unsigned DefDataW     = 10;
  localparam int unsigned DefWeightW   = 10;
  localparam int unsigned DefAccW      = 24;
  localparam int unsigned DefOutW      = 10;
  localparam int unsigned DefFracShift = 8;

  // Clamp a wide signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] satSigned(input logic signed [63:0] x,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Output conversion: ReLU into an unsigned w-bit word, or signed saturation.
  function automatic logic signed [63:0] convertOut(input logic signed [63:0] x,
                                                     input int unsigned w,
                                                     input bit relu);
    logic signed [63:0] hi;
    if (!relu) return satSigned(x, w);
    hi = (64'sd1 <<< w) - 64'sd1;
    if (x < 64'sd0) return 64'sd0;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/hidden_neuron_mac_mult.sv
// Registered signed multiplier: zero-extended unsigned data times signed weight,
// one pipeline stage with a travelling valid bit.
module hl_signed_mult #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned WEIGHT_W = 10
) (
  input  logic                              Clock,
  input  logic                              Clear,
  input  logic                              validIn,
  input  logic [DATA_W-1:0]                 dataIn,
  input  logic signed [WEIGHT_W-1:0]        weightIn,
  output logic                              validOut,
  output logic signed [DATA_W+WEIGHT_W:0]   product
);

  localparam int unsigned ProdW = DATA_W + WEIGHT_W + 1;

  logic signed [DATA_W:0] dataExt;

  assign dataExt = $signed({1'b0, dataIn});

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      validOut <= 1'b0;
      product  <= '0;
    end else begin
      validOut <= validIn;
      if (validIn) product <= ProdW'(dataExt) * ProdW'(weightIn);
    end
  end

endmodule

// File: rtl/hidden_neuron_mac.sv
// Single hidden-layer neuron: NUM_IN weighted beats are summed into a
// saturating accumulator seeded with a bias, then rescaled and held for output.
module hidden_neuron_mac
  import hidden_layer_pkg::*;
#(
  parameter int unsigned NUM_IN     = DefNumIn,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned WEIGHT_W   = DefWeightW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned OUT_W      = DefOutW,
  parameter int unsigned FRAC_SHIFT = DefFracShift,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                       Clock,
  input  logic                       Clear,
  input  logic                       start,
  input  logic signed [ACC_W-1:0]    bias,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic signed [WEIGHT_W-1:0] in_weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_val,
  output logic                       busy
);

  localparam int unsigned ProdW = DATA_W + WEIGHT_W + 1;
  localparam int unsigned CntW  = $clog2(NUM_IN + 1);

  macState_t state;
  macState_t stateNext;

  logic [CntW-1:0]            beatCount;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    accSum;
  logic                       beatValid;
  logic [DATA_W-1:0]          beatData;
  logic signed [WEIGHT_W-1:0] beatWeight;
  logic                       prodValid;
  logic signed [ProdW-1:0]    product;
  logic [OUT_W-1:0]           outConv;

  logic beatFire;
  logic lastBeat;
  logic pipeEmpty;
  logic loadBias;
  logic countBeat;
  logic loadOut;
  logic retireOut;

  assign beatFire  = in_valid && in_ready;
  assign lastBeat  = (beatCount == CntW'(NUM_IN - 1));
  assign pipeEmpty = !beatValid && !prodValid;
  assign accSum    = ACC_W'(satSigned(64'(acc) + 64'(product), ACC_W));
  assign outConv   = OUT_W'(convertOut(64'(acc) >>> FRAC_SHIFT, OUT_W, RELU_EN));

  // Accepted beats are captured first, so the product lands one edge later.
  hl_signed_mult #(
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W)
  ) uMult (
    .Clock   (Clock),
    .Clear   (Clear),
    .validIn (beatValid),
    .dataIn  (beatData),
    .weightIn(beatWeight),
    .validOut(prodValid),
    .product (product)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadBias  = 1'b0;
    countBeat = 1'b0;
    loadOut   = 1'b0;
    retireOut = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          loadBias  = 1'b1;
          stateNext = ACCUM;
        end
      end
      ACCUM: begin
        if (beatFire) begin
          countBeat = 1'b1;
          if (lastBeat) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (pipeEmpty) begin
          loadOut   = 1'b1;
          stateNext = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          retireOut = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      acc        <= '0;
      beatCount  <= '0;
      beatValid  <= 1'b0;
      beatData   <= '0;
      beatWeight <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_val    <= '0;
      busy       <= 1'b0;
    end else begin
      busy      <= (stateNext != IDLE);
      beatValid <= beatFire;
      if (beatFire) begin
        beatData   <= in_data;
        beatWeight <= in_weight;
      end
      if (loadBias) begin
        acc       <= bias;
        beatCount <= '0;
        in_ready  <= 1'b1;
      end else if (prodValid) begin
        acc <= accSum;
      end
      if (countBeat) begin
        beatCount <= beatCount + CntW'(1);
        if (lastBeat) in_ready <= 1'b0;
      end
      if (loadOut) begin
        out_val   <= outConv;
        out_valid <= 1'b1;
      end
      if (retireOut) out_valid <= 1'b0;
    end
  end

endmodule
